// File: rtl/unlock_key_pkg.sv
// Shared types and sizing helpers for the unlock key checker.
package unlock_key_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        LOCKOUT = 2'd3
    } ukc_state_t;

    function automatic int fail_count_width(input int max_fails);
        return (max_fails < 1) ? 1 : $clog2(max_fails + 1);
    endfunction

    // A single-word key still needs a one-bit index register.
    function automatic int index_width(input int key_len);
        return (key_len > 1) ? $clog2(key_len) : 1;
    endfunction

endpackage

// File: rtl/unlock_key_checker_lockout_timer.sv
// Down-counter for the failed-attempt lockout; busy spans exactly CYCLES cycles after load.
module lockout_timer #(
    parameter int CYCLES = 1024,
    localparam int CNT_W = $clog2(CYCLES + 1)
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    output logic busy,
    output logic done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
            busy  <= 1'b0;
        end else if (load) begin
            count <= CNT_W'(CYCLES - 1);
            busy  <= 1'b1;
        end else if (busy) begin
            if (count == '0) begin
                busy <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign done = busy && (count == '0);

endmodule

// File: rtl/unlock_key_checker.sv
// Accepts KEY_LEN key words over valid/ready, pulses unlock on a full match,
// and enforces a timed lockout after MAX_FAILS consecutive failures.
module unlock_key_checker
    import unlock_key_pkg::*;
#(
    parameter int                        KEY_W          = 32,
    parameter int                        KEY_LEN        = 4,
    parameter logic [KEY_LEN*KEY_W-1:0]  KEY            = '0,
    parameter int                        MAX_FAILS      = 3,
    parameter int                        LOCKOUT_CYCLES = 1024
) (
    input  logic                                     clk,
    input  logic                                     resetn,
    input  logic                                     key_valid,
    input  logic [KEY_W-1:0]                         key_data,
    output logic                                     key_ready,
    input  logic                                     abort,
    output logic                                     unlock,
    output logic                                     lockout,
    output logic [fail_count_width(MAX_FAILS)-1:0]   fail_count
);

    localparam int              FC_W   = fail_count_width(MAX_FAILS);
    localparam int              IDX_W  = index_width(KEY_LEN);
    localparam logic [FC_W-1:0] FC_MAX = FC_W'(MAX_FAILS);

    // Handshake: a word transfers on a rising edge where key_valid && key_ready;
    // key_ready depends only on state and abort, never on key_valid.

    ukc_state_t       state, state_next;
    logic [IDX_W-1:0] idx;
    logic             bad;
    logic             accept, last_word, mismatch, trip;
    logic             attempt_failed, attempt_passed;
    logic             timer_load, timer_busy, timer_done;

    assign last_word = (int'(idx) == KEY_LEN - 1);
    assign mismatch  = (key_data != KEY[int'(idx)*KEY_W +: KEY_W]);
    assign trip      = (int'(fail_count) + 1 >= MAX_FAILS);

    always_comb begin
        state_next     = state;
        key_ready      = 1'b0;
        accept         = 1'b0;
        attempt_failed = 1'b0;
        attempt_passed = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                key_ready = !abort;
                if (abort) begin
                    attempt_failed = (state == COLLECT);
                end else if (key_valid) begin
                    accept     = 1'b1;
                    state_next = last_word ? CHECK : COLLECT;
                end
            end
            CHECK: begin
                attempt_failed = bad;
                attempt_passed = !bad;
                state_next     = IDLE;
            end
            LOCKOUT: begin
                if (timer_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Aborts and bad checks share one failure path.
        timer_load = attempt_failed && trip;
        if (attempt_failed) state_next = trip ? LOCKOUT : IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            idx        <= '0;
            bad        <= 1'b0;
            unlock     <= 1'b0;
            fail_count <= '0;
        end else begin
            state  <= state_next;
            unlock <= attempt_passed;
            if (state_next == IDLE || state_next == LOCKOUT) begin
                idx <= '0;
                bad <= 1'b0;
            end else if (accept) begin
                bad <= bad | mismatch;
                if (!last_word) idx <= idx + 1'b1;
            end
            if (attempt_passed) begin
                fail_count <= '0;
            end else if (attempt_failed) begin
                fail_count <= trip ? FC_MAX : fail_count + 1'b1;
            end else if (state == LOCKOUT && timer_done) begin
                fail_count <= '0;
            end
        end
    end

    lockout_timer #(
        .CYCLES(LOCKOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .resetn(resetn),
        .load  (timer_load),
        .busy  (timer_busy),
        .done  (timer_done)
    );

    // The timer's busy flag is registered and spans exactly the lockout window.
    assign lockout = timer_busy;

endmodule

// File: tb/tb_unlock_key_checker.sv
// Directed bench for unlock_key_checker: attempt-level model checked every cycle
// plus literal expectations, on a 4-word build and a 1-word build.
module tb_unlock_key_checker;

    localparam int          KEY_W     = 32;
    localparam int          KEY_LEN   = 4;
    localparam int          MAX_FAILS = 3;
    localparam int          LOCK_CYC  = 16;
    localparam logic [31:0] WA        = 32'h1111_000A;
    localparam logic [31:0] WB        = 32'h2222_000B;
    localparam logic [31:0] WC        = 32'h3333_000C;
    localparam logic [31:0] WD        = 32'h4444_000D;
    localparam logic [31:0] WX        = 32'hDEAD_BEEF;
    localparam logic [KEY_LEN*KEY_W-1:0] KEY4 = {WD, WC, WB, WA};

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        key_valid = 1'b0, abort = 1'b0;
    logic [31:0] key_data = '0;
    logic        key_ready, unlock, lockout;
    logic [1:0]  fail_count;
    logic        key_valid1 = 1'b0, abort1 = 1'b0;
    logic [31:0] key_data1 = '0;
    logic        key_ready1, unlock1, lockout1;
    logic [1:0]  fail_count1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    unlock_key_checker #(
        .KEY_W(KEY_W), .KEY_LEN(KEY_LEN), .KEY(KEY4),
        .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYCLES(LOCK_CYC)
    ) dut (
        .clk(clk), .resetn(resetn), .key_valid(key_valid), .key_data(key_data),
        .key_ready(key_ready), .abort(abort), .unlock(unlock), .lockout(lockout),
        .fail_count(fail_count)
    );

    unlock_key_checker #(
        .KEY_W(KEY_W), .KEY_LEN(1), .KEY(WA),
        .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYCLES(LOCK_CYC)
    ) dut1 (
        .clk(clk), .resetn(resetn), .key_valid(key_valid1), .key_data(key_data1),
        .key_ready(key_ready1), .abort(abort1), .unlock(unlock1), .lockout(lockout1),
        .fail_count(fail_count1)
    );

    // Attempt-level model of the 4-word build.
    logic [31:0] att_q[$];
    logic [31:0] key_words[KEY_LEN] = '{WA, WB, WC, WD};
    bit          m_check;
    bit          m_unlock;
    int          m_lock;
    int          m_fails;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit attempt_ok();
        for (int i = 0; i < KEY_LEN; i++)
            if (att_q[i] != key_words[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_fail();
        m_fails++;
        if (m_fails >= MAX_FAILS) begin
            m_fails = MAX_FAILS;
            m_lock  = LOCK_CYC;
        end
    endtask

    always @(negedge resetn) begin
        att_q.delete();
        m_check  = 1'b0;
        m_unlock = 1'b0;
        m_lock   = 0;
        m_fails  = 0;
    end

    always @(posedge clk) begin
        if (resetn) begin
            m_unlock = 1'b0;
            if (m_check) begin
                m_check = 1'b0;
                if (attempt_ok()) begin
                    m_unlock = 1'b1;
                    m_fails  = 0;
                end else begin
                    model_fail();
                end
                att_q.delete();
            end else if (m_lock > 0) begin
                m_lock--;
                if (m_lock == 0) m_fails = 0;
            end else if (abort) begin
                if (att_q.size() > 0) begin
                    att_q.delete();
                    model_fail();
                end
            end else if (key_valid) begin
                att_q.push_back(key_data);
                if (att_q.size() == KEY_LEN) m_check = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            check("ready", key_ready, !abort && !m_check && m_lock == 0);
            check("unlock", unlock, m_unlock);
            check("lockout", lockout, m_lock > 0);
            check("fail_count", fail_count, m_fails);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        bit acc = 1'b0;
        key_valid = 1'b1;
        key_data  = w;
        while (!acc && n < 64) begin
            @(negedge clk);
            acc = key_ready;
            tick();
            n++;
        end
        key_valid = 1'b0;
        if (!acc) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_word: got no accept expected accept within 64 cycles");
        end
    endtask

    task automatic send_word1(input logic [31:0] w);
        int n = 0;
        bit acc = 1'b0;
        key_valid1 = 1'b1;
        key_data1  = w;
        while (!acc && n < 64) begin
            @(negedge clk);
            acc = key_ready1;
            tick();
            n++;
        end
        key_valid1 = 1'b0;
        if (!acc) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_word1: got no accept expected accept within 64 cycles");
        end
    endtask

    task automatic send4(input logic [31:0] a, b, c, d);
        send_word(a);
        send_word(b);
        send_word(c);
        send_word(d);
    endtask

    task automatic do_reset(input string tag);
        resetn = 1'b0;
        #1;
        check({tag, "_unlock"}, unlock, 0);
        check({tag, "_lockout"}, lockout, 0);
        check({tag, "_fail"}, fail_count, 0);
        check({tag, "_ready"}, key_ready, 1);
        check({tag, "_lockout1"}, lockout1, 0);
        @(posedge clk);
        #2;
        resetn = 1'b1;
    endtask

    initial begin
        int cnt;
        #2;
        do_reset("rst0");

        // Correct key back to back.
        send4(WA, WB, WC, WD);
        #1;
        check("check_ready_low", key_ready, 0);
        tick();
        check("good_unlock", unlock, 1);
        check("good_fail", fail_count, 0);
        tick();
        check("good_unlock_1cyc", unlock, 0);

        // Wrong second word, then recovery.
        send4(WA, WX, WC, WD);
        tick();
        check("bad_unlock", unlock, 0);
        check("bad_fail", fail_count, 1);
        send4(WA, WB, WC, WD);
        tick();
        check("recover_unlock", unlock, 1);
        check("recover_fail", fail_count, 0);

        // Three failures -> lockout with key_valid held.
        repeat (3) send4(WX, WB, WC, WD);
        tick();
        check("lock_rise", lockout, 1);
        check("lock_fail", fail_count, 3);
        key_valid = 1'b1;
        key_data  = WA;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!lockout) break;
            cnt++;
        end
        key_valid = 1'b0;
        check("lock_len", cnt, LOCK_CYC);
        check("lock_end_fail", fail_count, 0);
        check("lock_end_ready", key_ready, 1);
        tick();
        send4(WA, WB, WC, WD);
        tick();
        check("post_lock_unlock", unlock, 1);

        // Abort with valid after two words, then abort in IDLE.
        send_word(WA);
        send_word(WB);
        key_valid = 1'b1;
        key_data  = WC;
        abort     = 1'b1;
        #1;
        check("abort_ready", key_ready, 0);
        tick();
        abort     = 1'b0;
        key_valid = 1'b0;
        check("abort_fail", fail_count, 1);
        abort = 1'b1;
        tick();
        tick();
        abort = 1'b0;
        check("idle_abort_fail", fail_count, 1);

        // Reset mid-attempt and mid-lockout.
        send_word(WA);
        send_word(WB);
        do_reset("rst_mid");
        repeat (3) send4(WX, WX, WX, WX);
        tick();
        repeat (4) tick();
        check("mid_lock_high", lockout, 1);
        do_reset("rst_lock");
        send4(WC, WD, WA, WB);
        tick();
        check("rot_unlock", unlock, 0);
        check("rot_fail", fail_count, 1);
        send4(WA, WB, WC, WD);
        tick();
        check("final_unlock", unlock, 1);
        check("final_fail", fail_count, 0);

        // Single-word build.
        send_word1(WA);
        #1;
        check("k1_ready_check", key_ready1, 0);
        check("k1_unlock_early", unlock1, 0);
        tick();
        check("k1_unlock", unlock1, 1);
        tick();
        check("k1_unlock_1cyc", unlock1, 0);
        send_word1(WX);
        tick();
        check("k1_fail1", fail_count1, 1);
        send_word1(WX);
        send_word1(WX);
        tick();
        check("k1_lockout", lockout1, 1);
        check("k1_fail3", fail_count1, 3);
        check("k1_lock_ready", key_ready1, 0);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
